// File: rtl/iir_output_checker.sv
// rtl/iir_output_checker.sv - compares filter output samples against a FIFO of expected values
//
// Ports:
//   clock, reset            rising-edge clock, synchronous active-high reset
//   exp_valid/exp_data      push an expected sample; exp_ready is high while the FIFO is not full
//   start, num_samples      arm a check of num_samples compares (ignored while busy)
//   sample_en, Data_out_r   filter output strobe and sample
//   busy, done, pass        status: busy in SKIP/RUN, one-cycle done pulse, pass valid in DONE
//   err_count               saturating mismatch count
//   first_err_idx           compare index of the first mismatch
//   underflow               sticky: a compare found the FIFO empty

module iir_output_checker #(
  parameter int WORD_SIZE = 64,
  parameter int FRAC_BIT  = 52,
  parameter int DEPTH     = 16,
  parameter int SKIP      = 2,
  parameter int TOL       = 64
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 exp_valid,
  input  logic [WORD_SIZE-1:0] exp_data,
  output logic                 exp_ready,
  input  logic                 start,
  input  logic [15:0]          num_samples,
  input  logic                 sample_en,
  input  logic [WORD_SIZE-1:0] Data_out_r,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [15:0]          err_count,
  output logic [15:0]          first_err_idx,
  output logic                 underflow
);

  localparam int AW = $clog2(DEPTH);
  // The binary point does not matter for an LSB-domain tolerance check; FRAC_BIT
  // only documents the sample format.
  localparam int DW = WORD_SIZE + 1 + 0 * FRAC_BIT;

  typedef enum logic [1:0] {S_IDLE, S_SKIP, S_RUN, S_DONE} state_t;
  state_t state;

  logic [WORD_SIZE-1:0] mem [DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [AW:0]          count;
  logic                 fifo_empty;
  logic                 fifo_full;

  logic [15:0] num_lat;
  logic [15:0] cmp_idx;
  logic [15:0] skip_cnt;

  logic                 compare;
  logic                 do_pop;
  logic                 do_push;
  logic signed [DW-1:0] diff;
  logic [DW-1:0]        abs_diff;
  logic                 mismatch;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == (AW+1)'(DEPTH));
  assign exp_ready  = !fifo_full;
  assign busy       = (state == S_SKIP) || (state == S_RUN);

  // A compare happens on every strobe in RUN until num_samples have been seen.
  // An empty FIFO still consumes a compare slot but cannot pop.
  assign compare = (state == S_RUN) && sample_en && (cmp_idx < num_lat);
  assign do_pop  = compare && !fifo_empty;
  // A pop in the same cycle frees a slot, so a push into a full FIFO is
  // accepted when it coincides with a compare.
  assign do_push = exp_valid && (!fifo_full || do_pop);

  // One extra bit keeps full-scale opposite-sign differences and their
  // magnitude representable.
  assign diff     = $signed({Data_out_r[WORD_SIZE-1], Data_out_r})
                  - $signed({mem[rd_ptr][WORD_SIZE-1], mem[rd_ptr]});
  assign abs_diff = diff[DW-1] ? $unsigned(-diff) : $unsigned(diff);
  assign mismatch = abs_diff > DW'(TOL);

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= exp_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= S_IDLE;
      num_lat       <= '0;
      cmp_idx       <= '0;
      skip_cnt      <= '0;
      done          <= 1'b0;
      pass          <= 1'b0;
      err_count     <= '0;
      first_err_idx <= '0;
      underflow     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            num_lat       <= num_samples;
            cmp_idx       <= '0;
            skip_cnt      <= 16'(SKIP);
            err_count     <= '0;
            first_err_idx <= '0;
            underflow     <= 1'b0;
            pass          <= 1'b0;
            if (SKIP == 0) begin
              if (num_samples == 16'd0) begin
                state <= S_DONE;
                done  <= 1'b1;
                pass  <= 1'b1;
              end else begin
                state <= S_RUN;
              end
            end else begin
              state <= S_SKIP;
            end
          end
        end
        S_SKIP: begin
          if (sample_en) begin
            if (skip_cnt <= 16'd1) begin
              // Nothing to compare: finish on the strobe that would enter RUN.
              if (num_lat == 16'd0) begin
                state <= S_DONE;
                done  <= 1'b1;
                pass  <= 1'b1;
              end else begin
                state <= S_RUN;
              end
            end else begin
              skip_cnt <= skip_cnt - 1'b1;
            end
          end
        end
        S_RUN: begin
          if (compare) begin
            cmp_idx <= cmp_idx + 1'b1;
            if (fifo_empty) begin
              underflow <= 1'b1;
            end else if (mismatch) begin
              if (err_count != 16'hFFFF) begin
                err_count <= err_count + 1'b1;
              end
              if (err_count == 16'd0) begin
                first_err_idx <= cmp_idx;
              end
            end
          end else if (cmp_idx == num_lat) begin
            state <= S_DONE;
            done  <= 1'b1;
            pass  <= (err_count == 16'd0) && !underflow;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
